spu_regfile_wb: RTL

SPU_REGFILE_WB -- requirements
Module: spu_regfile_wb

---
 rtl/spu_regfile_wb_if.sv | 42 ++++
 rtl/spu_regfile_wb.sv | 92 +++++++++
 2 files changed

// File: rtl/spu_regfile_wb_if.sv
// Operand-read, writeback and issue bundle for the SPU register file.
// master drives addresses, writebacks and issue; slave returns operands and stall.
interface spu_regfile_wb_if #(
  parameter int DATA_W = 128
);
  logic [6:0]        ra_addr;
  logic [6:0]        rb_addr;
  logic [6:0]        rc_addr;
  logic [2:0]        src_en;
  logic [DATA_W-1:0] ra;
  logic [DATA_W-1:0] rb;
  logic [DATA_W-1:0] rc;

  logic [DATA_W-1:0] rt_wb;
  logic [6:0]        rt_addr_wb;
  logic              reg_write_wb;

  logic [DATA_W-1:0] rt_int;
  logic [6:0]        rt_addr_int;
  logic              reg_write_int;

  logic              issue_valid;
  logic [6:0]        issue_rt_addr;
  logic [2:0]        issue_latency;
  logic              stall;

  modport master (
    output ra_addr, rb_addr, rc_addr, src_en,
    output rt_wb, rt_addr_wb, reg_write_wb,
    output rt_int, rt_addr_int, reg_write_int,
    output issue_valid, issue_rt_addr, issue_latency,
    input  ra, rb, rc, stall
  );

  modport slave (
    input  ra_addr, rb_addr, rc_addr, src_en,
    input  rt_wb, rt_addr_wb, reg_write_wb,
    input  rt_int, rt_addr_int, reg_write_int,
    input  issue_valid, issue_rt_addr, issue_latency,
    output ra, rb, rc, stall
  );
endinterface

// File: rtl/spu_regfile_wb.sv
// 128x128 SPU register file with two writeback ports, bypass forwarding and a
// latency-countdown scoreboard that stalls issue on outstanding operands.
module spu_regfile_wb #(
  parameter int DATA_W = 128
) (
  input  logic            clk,
  input  logic            reset,
  spu_regfile_wb_if.slave rf
);
  localparam int NREG = 128;
  localparam int AW   = 7;
  localparam int CW   = 3;

  logic [DATA_W-1:0] mem      [NREG];
  logic [CW-1:0]     pend     [NREG];
  logic [CW-1:0]     pend_nxt [NREG];
  logic              dep_busy;
  logic              accept;

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    return (c == '0) ? '0 : c - CW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_max(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // wb port belongs to the younger instruction, so it outranks int
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [AW-1:0]     a,
    input logic              wb_en,
    input logic [AW-1:0]     wb_a,
    input logic [DATA_W-1:0] wb_d,
    input logic              int_en,
    input logic [AW-1:0]     int_a,
    input logic [DATA_W-1:0] int_d,
    input logic [DATA_W-1:0] arr_d
  );
    if (wb_en && wb_a == a)   return wb_d;
    if (int_en && int_a == a) return int_d;
    return arr_d;
  endfunction

  always_comb begin
    rf.ra = '0;
    rf.rb = '0;
    rf.rc = '0;
    if (reset) begin
      rf.ra = fwd_sel(rf.ra_addr, rf.reg_write_wb, rf.rt_addr_wb, rf.rt_wb,
                      rf.reg_write_int, rf.rt_addr_int, rf.rt_int, mem[rf.ra_addr]);
      rf.rb = fwd_sel(rf.rb_addr, rf.reg_write_wb, rf.rt_addr_wb, rf.rt_wb,
                      rf.reg_write_int, rf.rt_addr_int, rf.rt_int, mem[rf.rb_addr]);
      rf.rc = fwd_sel(rf.rc_addr, rf.reg_write_wb, rf.rt_addr_wb, rf.rt_wb,
                      rf.reg_write_int, rf.rt_addr_int, rf.rt_int, mem[rf.rc_addr]);
    end
  end

  // A count of 1 lands this cycle and is covered by forwarding, so only >1 blocks
  always_comb begin
    dep_busy = (rf.src_en[2] && pend[rf.ra_addr] > CW'(1)) ||
               (rf.src_en[1] && pend[rf.rb_addr] > CW'(1)) ||
               (rf.src_en[0] && pend[rf.rc_addr] > CW'(1));
    rf.stall = reset && rf.issue_valid && dep_busy;
    accept   = rf.issue_valid && !dep_busy;
  end

  // Newer issue never shortens an older outstanding write
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_nxt[i] = sat_dec(pend[i]);
      if (accept && rf.issue_latency != '0 && rf.issue_rt_addr == AW'(i))
        pend_nxt[i] = cnt_max(sat_dec(pend[i]), rf.issue_latency);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) pend[i] <= pend_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (rf.reg_write_int) mem[rf.rt_addr_int] <= rf.rt_int;
      if (rf.reg_write_wb)  mem[rf.rt_addr_wb]  <= rf.rt_wb;
    end
  end
endmodule
